memory_access: RTL and testbench

- Pipeline MEM stage; sits directly downstream of the Execute stage and consumes its EX/MEM pipeline register outputs.
- Performs byte, halfword and word loads and stores against a local word-organised data memory.
- Registers the results into the MEM/WB pipeline register.
- Exposes the MEM-stage destination register and write enable for the forwarding unit, plus a debug memory read port.

---
 rtl/memory_access.sv | 157 +++++++++++++++
 tb/tb_memory_access.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Pipeline MEM stage: byte/half/word loads and stores against a local word-organised
// data memory, results registered into MEM/WB on the falling clock edge.
module memory_access #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        inWB,
    input  logic [2:0]        inMEM,
    input  logic [2:0]        inLSType,
    input  logic [31:0]       inALUResult,
    input  logic [31:0]       inRegB,
    input  logic [4:0]        inRegF_wreg,
    input  logic              stop_debug,
    input  logic [ADDR_W-1:0] debug_addr,
    output logic [4:0]        outWB,
    output logic [31:0]       outALUResult,
    output logic [31:0]       outMemData,
    output logic [4:0]        outRegF_wreg,
    output logic [4:0]        MEM_rd,
    output logic              MEM_regF_wr,
    output logic              outMisaligned,
    output logic [31:0]       debug_data
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    logic [31:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        lane_s;
    size_e             size_s;
    logic              unsigned_s;
    logic              misaligned_s;
    logic              access_s;
    logic              we_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       rd_shift_s;
    logic [31:0]       load_s;
    logic [3:0]        byte_en_s;
    logic [31:0]       wdata_s;
    logic [31:0]       merged_s;
    logic              unused_s;

    assign word_idx_s  = inALUResult[ADDR_W+1:2];
    assign lane_s      = inALUResult[1:0];
    assign access_s    = inMEM[1] | inMEM[0];
    assign rd_word_s   = mem_r[word_idx_s];
    assign rd_shift_s  = rd_word_s >> {lane_s, 3'b000};
    assign we_s        = inMEM[0] & ~misaligned_s & ~stop_debug;
    assign MEM_rd      = inRegF_wreg;
    assign MEM_regF_wr = inWB[0];
    assign debug_data  = mem_r[debug_addr];
    assign unused_s    = ^{1'b0, inMEM[2], inALUResult[31:ADDR_W+2]};

    // Access-type decode; reserved encodings fall back to a word access.
    always_comb begin
        size_s     = SZ_WORD;
        unsigned_s = 1'b0;
        case (inLSType)
            3'b000:  size_s = SZ_BYTE;
            3'b100: begin
                size_s     = SZ_BYTE;
                unsigned_s = 1'b1;
            end
            3'b001:  size_s = SZ_HALF;
            3'b101: begin
                size_s     = SZ_HALF;
                unsigned_s = 1'b1;
            end
            default: size_s = SZ_WORD;
        endcase
    end

    // Alignment check against the lane of the addressed word.
    always_comb begin
        misaligned_s = 1'b0;
        case (size_s)
            SZ_HALF: misaligned_s = lane_s[0];
            SZ_WORD: misaligned_s = (lane_s != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
    end

    // Load data: pre-write word contents, lane-shifted and extended.
    always_comb begin
        load_s = 32'd0;
        if (inMEM[1] && !misaligned_s) begin
            case (size_s)
                SZ_BYTE: load_s = unsigned_s ? {24'd0, rd_shift_s[7:0]}
                                             : {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
                SZ_HALF: load_s = unsigned_s ? {16'd0, rd_shift_s[15:0]}
                                             : {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
                default: load_s = rd_word_s;
            endcase
        end else begin
            load_s = 32'd0;
        end
    end

    // Store merge: replicate store data across lanes, keep bytes outside the enable mask.
    always_comb begin
        byte_en_s = 4'b1111;
        wdata_s   = inRegB;
        merged_s  = rd_word_s;
        case (size_s)
            SZ_BYTE: begin
                byte_en_s = 4'b0001 << lane_s;
                wdata_s   = {4{inRegB[7:0]}};
            end
            SZ_HALF: begin
                byte_en_s = 4'b0011 << lane_s;
                wdata_s   = {2{inRegB[15:0]}};
            end
            default: begin
                byte_en_s = 4'b1111;
                wdata_s   = inRegB;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (byte_en_s[i]) begin
                merged_s[8*i +: 8] = wdata_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(negedge clk) begin
        if (we_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    // MEM/WB pipeline register and sticky misalignment flag, frozen by stop_debug.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            outWB         <= 5'd0;
            outALUResult  <= 32'd0;
            outMemData    <= 32'd0;
            outRegF_wreg  <= 5'd0;
            outMisaligned <= 1'b0;
        end else if (!stop_debug) begin
            outWB         <= inWB;
            outALUResult  <= inALUResult;
            outMemData    <= load_s;
            outRegF_wreg  <= inRegF_wreg;
            outMisaligned <= outMisaligned | (access_s & misaligned_s);
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus random traffic
// against a byte-addressed reference model of the data memory and MEM/WB register.
module tb_memory_access;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        inWB;
    logic [2:0]        inMEM;
    logic [2:0]        inLSType;
    logic [31:0]       inALUResult;
    logic [31:0]       inRegB;
    logic [4:0]        inRegF_wreg;
    logic              stop_debug;
    logic [ADDR_W-1:0] debug_addr;
    logic [4:0]        outWB;
    logic [31:0]       outALUResult;
    logic [31:0]       outMemData;
    logic [4:0]        outRegF_wreg;
    logic [4:0]        MEM_rd;
    logic              MEM_regF_wr;
    logic              outMisaligned;
    logic [31:0]       debug_data;

    memory_access #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .inWB(inWB), .inMEM(inMEM), .inLSType(inLSType),
        .inALUResult(inALUResult), .inRegB(inRegB), .inRegF_wreg(inRegF_wreg),
        .stop_debug(stop_debug), .debug_addr(debug_addr), .outWB(outWB),
        .outALUResult(outALUResult), .outMemData(outMemData), .outRegF_wreg(outRegF_wreg),
        .MEM_rd(MEM_rd), .MEM_regF_wr(MEM_regF_wr), .outMisaligned(outMisaligned),
        .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_miss   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [4:0]  exp_wb;
    logic [31:0] exp_alu;
    logic [31:0] exp_md;
    logic [4:0]  exp_rd;
    logic        exp_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        logic [31:0] w;
        w = model_mem[(a >> 2) % DEPTH];
        return 8'(w >> (8 * (a % 4)));
    endfunction

    task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
        int idx;
        int sh;
        idx = int'((a >> 2) % DEPTH);
        sh  = int'(8 * (a % 4));
        model_mem[idx] = (model_mem[idx] & ~(32'hFF << sh)) | (32'(b) << sh);
    endtask

    function automatic int size_of(input logic [2:0] lst);
        case (lst)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int sz, input bit sgn);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(get_byte(a + 32'(k))) << (8 * k));
        if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    // One transaction: drive after posedge, check pre-write debug, update model, check after negedge.
    task automatic step(input logic [4:0] wb, input logic [2:0] mc, input logic [2:0] lst,
                        input logic [31:0] addr, input logic [31:0] regb, input logic [4:0] rd,
                        input logic stop, input bit pre_dbg);
        int sz;
        bit mis;
        logic [31:0] ld;
        @(posedge clk);
        #1;
        inWB = wb; inMEM = mc; inLSType = lst; inALUResult = addr;
        inRegB = regb; inRegF_wreg = rd; stop_debug = stop;
        debug_addr = addr[ADDR_W+1:2];
        #1;
        if (pre_dbg) chk("dbg_pre", debug_data, model_mem[addr[ADDR_W+1:2]]);
        chk("mem_rd", MEM_rd, rd);
        chk("mem_regf_wr", MEM_regF_wr, wb[0]);
        sz  = size_of(lst);
        mis = (addr % sz) != 0;
        ld  = (mc[1] && !mis) ? ref_load(addr, sz, !lst[2]) : 32'd0;
        if (!stop) begin
            exp_wb = wb; exp_alu = addr; exp_md = ld; exp_rd = rd;
            if ((mc[1] || mc[0]) && mis) exp_mis = 1'b1;
            if (mc[0] && !mis) begin
                for (int k = 0; k < sz; k++) put_byte(addr + 32'(k), 8'(regb >> (8 * k)));
            end
        end
        @(negedge clk);
        #1;
        chk("out_wb", outWB, exp_wb);
        chk("out_alu", outALUResult, exp_alu);
        chk("out_memdata", outMemData, exp_md);
        chk("out_rd", outRegF_wreg, exp_rd);
        chk("out_mis", outMisaligned, exp_mis);
        chk("dbg_post", debug_data, model_mem[addr[ADDR_W+1:2]]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb"}, outWB, 32'd0);
        chk({tag, "_alu"}, outALUResult, 32'd0);
        chk({tag, "_md"}, outMemData, 32'd0);
        chk({tag, "_rd"}, outRegF_wreg, 32'd0);
        chk({tag, "_mis"}, outMisaligned, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; inWB = 5'd0; inMEM = 3'd0; inLSType = 3'd0; inALUResult = 32'd0;
        inRegB = 32'd0; inRegF_wreg = 5'd0; stop_debug = 1'b0; debug_addr = '0;
        exp_wb = 5'd0; exp_alu = 32'd0; exp_md = 32'd0; exp_rd = 5'd0; exp_mis = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Preload every word so later loads compare against known contents.
        for (int i = 0; i < DEPTH; i++)
            step(5'(i), 3'b001, 3'b011, 32'(i * 4), $urandom, 5'(i), 1'b0, 1'b0);

        step(5'h03, 3'b001, 3'b011, 32'h10, 32'hDEADBEEF, 5'd1, 1'b0, 1'b1);
        step(5'h03, 3'b010, 3'b011, 32'h10, 32'h0, 5'd2, 1'b0, 1'b1);
        chk("lw_0x10", outMemData, 32'hDEADBEEF);
        chk("dbg_idx4", debug_data, 32'hDEADBEEF);

        step(5'h00, 3'b001, 3'b011, 32'h20, 32'h0000_80F0, 5'd3, 1'b0, 1'b1);
        step(5'h03, 3'b010, 3'b000, 32'h20, 32'h0, 5'd4, 1'b0, 1'b1);
        chk("lb", outMemData, 32'hFFFF_FFF0);
        step(5'h03, 3'b010, 3'b100, 32'h20, 32'h0, 5'd4, 1'b0, 1'b1);
        chk("lbu", outMemData, 32'h0000_00F0);
        step(5'h03, 3'b010, 3'b001, 32'h20, 32'h0, 5'd4, 1'b0, 1'b1);
        chk("lh", outMemData, 32'hFFFF_80F0);
        step(5'h03, 3'b010, 3'b101, 32'h20, 32'h0, 5'd4, 1'b0, 1'b1);
        chk("lhu", outMemData, 32'h0000_80F0);

        step(5'h00, 3'b001, 3'b011, 32'h30, 32'h1122_3344, 5'd5, 1'b0, 1'b1);
        step(5'h00, 3'b001, 3'b000, 32'h31, 32'h0000_00AA, 5'd5, 1'b0, 1'b1);
        chk("sb_0x31", debug_data, 32'h1122_AA44);
        step(5'h00, 3'b001, 3'b001, 32'h32, 32'h0000_BEEF, 5'd5, 1'b0, 1'b1);
        chk("sh_0x32", debug_data, 32'hBEEF_AA44);
        step(5'h03, 3'b011, 3'b001, 32'h30, 32'h0000_1234, 5'd6, 1'b0, 1'b1);
        chk("rmw_pre_data", outMemData, 32'hFFFF_AA44);

        step(5'h00, 3'b001, 3'b011, 32'h40, 32'h0BAD_F00D, 5'd6, 1'b0, 1'b1);
        step(5'h00, 3'b001, 3'b011, 32'h41, 32'h1234_5678, 5'd6, 1'b0, 1'b1);
        chk("mis_nowrite", debug_data, 32'h0BAD_F00D);
        chk("mis_set", outMisaligned, 32'd1);
        step(5'h03, 3'b010, 3'b011, 32'h40, 32'h0, 5'd7, 1'b0, 1'b1);
        chk("mis_sticky", outMisaligned, 32'd1);

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        exp_wb = 5'd0; exp_alu = 32'd0; exp_md = 32'd0; exp_rd = 5'd0; exp_mis = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;

        step(5'h1F, 3'b010, 3'b011, 32'h10, 32'h0, 5'd9, 1'b0, 1'b1);
        step(5'h00, 3'b001, 3'b011, 32'h50, 32'h0000_0005, 5'd8, 1'b1, 1'b1);
        chk("stall_hold_alu", outALUResult, 32'h10);
        step(5'h00, 3'b001, 3'b011, 32'h400, 32'hCAFE_F00D, 5'd7, 1'b0, 1'b1);
        chk("wrap_idx0", debug_data, 32'hCAFE_F00D);

        for (int i = 0; i < 200; i++)
            step(5'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, 5'($urandom), ($urandom_range(0, 7) == 0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
